// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared FSM encoding and default constants for hazard_stall_ctrl
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hsc_state_e;

    localparam int unsigned HSC_CNT_WIDTH_DEF     = 16;
    localparam int unsigned HSC_STALL_TIMEOUT_DEF = 3;

    // Width needed to hold run-lengths 0..timeout inclusive.
    function automatic int unsigned hsc_rl_width(input int unsigned timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that saturates at all-ones, synchronous active-high reset
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline stall/flush controller; HSC_PERF_CNT_EN adds stall/flush counters
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH     = HSC_CNT_WIDTH_DEF,
    parameter int unsigned STALL_TIMEOUT = HSC_STALL_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 DHS,
    input  logic                 BR_TAKEN,
    output logic                 PC_HOLD,
    output logic                 IF_DOF_HOLD,
    output logic                 IF_DOF_FLUSH,
    output logic                 DOF_EX_BUBBLE,
    output logic                 STALL_TIMEOUT_ERR,
    output logic [CNT_WIDTH-1:0] STALL_CNT,
    output logic [CNT_WIDTH-1:0] FLUSH_CNT
);

    localparam int unsigned     RL_W   = hsc_rl_width(STALL_TIMEOUT);
    localparam logic [RL_W-1:0] RL_MAX = RL_W'(STALL_TIMEOUT);

    hsc_state_e      state_q, state_d;
    logic [RL_W-1:0] run_len_q, run_len_d;
    logic            err_q, err_d;

    // Control outputs follow the current inputs so the action lands on this edge.
    always_comb begin
        state_d       = state_q;
        run_len_d     = run_len_q;
        err_d         = err_q;
        PC_HOLD       = 1'b0;
        IF_DOF_HOLD   = 1'b0;
        IF_DOF_FLUSH  = 1'b0;
        DOF_EX_BUBBLE = 1'b0;

        if (reset) begin
            state_d   = ST_RUN;
            run_len_d = '0;
            err_d     = 1'b0;
        end else if (BR_TAKEN) begin
            IF_DOF_FLUSH  = 1'b1;
            DOF_EX_BUBBLE = 1'b1;
            state_d       = ST_FLUSH;
            run_len_d     = '0;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    // DOF holds the NOP injected by the flush, so DHS is stale here.
                    state_d   = ST_RUN;
                    run_len_d = '0;
                end
                default: begin
                    if (DHS) begin
                        PC_HOLD       = 1'b1;
                        IF_DOF_HOLD   = 1'b1;
                        DOF_EX_BUBBLE = 1'b1;
                        state_d       = ST_STALL;
                        if (state_q == ST_STALL) begin
                            if (run_len_q == RL_MAX) begin
                                err_d = 1'b1;
                            end else begin
                                run_len_d = run_len_q + RL_W'(1);
                            end
                        end
                    end else begin
                        state_d   = ST_RUN;
                        run_len_d = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            run_len_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_len_q <= run_len_d;
            err_q     <= err_d;
        end
    end

    assign STALL_TIMEOUT_ERR = err_q;

`ifdef HSC_PERF_CNT_EN
    logic stall_evt;
    logic flush_evt;

    // A bubble without a flush can only come from a data-hazard stall.
    assign stall_evt = DOF_EX_BUBBLE & ~IF_DOF_FLUSH;
    assign flush_evt = IF_DOF_FLUSH;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_evt),
        .count (STALL_CNT)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_evt),
        .count (FLUSH_CNT)
    );
`else
    assign STALL_CNT = '0;
    assign FLUSH_CNT = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    localparam int unsigned CW = 4;
    localparam int unsigned TO = 3;
`ifdef HSC_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          DHS;
    logic          BR_TAKEN;
    logic          PC_HOLD;
    logic          IF_DOF_HOLD;
    logic          IF_DOF_FLUSH;
    logic          DOF_EX_BUBBLE;
    logic          STALL_TIMEOUT_ERR;
    logic [CW-1:0] STALL_CNT;
    logic [CW-1:0] FLUSH_CNT;

    hazard_stall_ctrl #(.CNT_WIDTH(CW), .STALL_TIMEOUT(TO)) dut (
        .clk               (clk),
        .reset             (reset),
        .DHS               (DHS),
        .BR_TAKEN          (BR_TAKEN),
        .PC_HOLD           (PC_HOLD),
        .IF_DOF_HOLD       (IF_DOF_HOLD),
        .IF_DOF_FLUSH      (IF_DOF_FLUSH),
        .DOF_EX_BUBBLE     (DOF_EX_BUBBLE),
        .STALL_TIMEOUT_ERR (STALL_TIMEOUT_ERR),
        .STALL_CNT         (STALL_CNT),
        .FLUSH_CNT         (FLUSH_CNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          pc;
        logic          hold;
        logic          fl;
        logic          bub;
        logic          err;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: 0=RUN 1=STALL 2=FLUSH
    int            m_state = 0;
    int            m_rl    = 0;
    logic          m_err   = 1'b0;
    logic [CW-1:0] m_sc    = '0;
    logic [CW-1:0] m_fc    = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic d, input logic b);
        exp_t e;
        exp_t o;
        logic stall_c;
        @(negedge clk);
        reset    = r;
        DHS      = d;
        BR_TAKEN = b;

        e         = '0;
        stall_c   = 1'b0;
        e.err     = m_err;
        e.sc      = m_sc;
        e.fc      = m_fc;
        if (!r) begin
            if (b) begin
                e.fl  = 1'b1;
                e.bub = 1'b1;
            end else if (m_state != 2 && d) begin
                e.pc    = 1'b1;
                e.hold  = 1'b1;
                e.bub   = 1'b1;
                stall_c = 1'b1;
            end
        end
        sb.push_back(e);

        #1;
        o = sb.pop_front();
        check_eq("pc_hold",       32'(PC_HOLD),           32'(o.pc));
        check_eq("if_dof_hold",   32'(IF_DOF_HOLD),       32'(o.hold));
        check_eq("if_dof_flush",  32'(IF_DOF_FLUSH),      32'(o.fl));
        check_eq("dof_ex_bubble", 32'(DOF_EX_BUBBLE),     32'(o.bub));
        check_eq("timeout_err",   32'(STALL_TIMEOUT_ERR), 32'(o.err));
        check_eq("stall_cnt",     32'(STALL_CNT),         32'(o.sc));
        check_eq("flush_cnt",     32'(FLUSH_CNT),         32'(o.fc));
        check_eq("hold_flush_excl", 32'(PC_HOLD & IF_DOF_FLUSH), 32'd0);

        // advance model to the state after the coming edge
        if (r) begin
            m_state = 0; m_rl = 0; m_err = 1'b0; m_sc = '0; m_fc = '0;
        end else begin
            if (PERF && stall_c && m_sc != {CW{1'b1}}) m_sc = m_sc + 1'b1;
            if (PERF && b && m_fc != {CW{1'b1}})       m_fc = m_fc + 1'b1;
            if (b) begin
                m_state = 2; m_rl = 0;
            end else if (m_state == 2) begin
                m_state = 0; m_rl = 0;
            end else if (d) begin
                if (m_state == 1) begin
                    if (m_rl == TO) m_err = 1'b1;
                    else            m_rl = m_rl + 1;
                end
                m_state = 1;
            end else begin
                m_state = 0; m_rl = 0;
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        DHS      = 1'b0;
        BR_TAKEN = 1'b0;

        // reset with noisy inputs must keep controls low
        step(1, 0, 0);
        step(1, 1, 1);
        repeat (5) step(0, 0, 0);

        // two-cycle data hazard
        step(0, 1, 0); step(0, 1, 0);
        repeat (2) step(0, 0, 0);

        // branch wins over hazard, then stale DHS ignored in FLUSH
        step(0, 1, 1); step(0, 1, 0); step(0, 0, 0);

        // timeout: error sticks after DHS drops, clears only on reset
        repeat (5) step(0, 1, 0);
        repeat (3) step(0, 0, 0);
        step(1, 0, 0); step(0, 0, 0);

        // reset in the middle of a 4-cycle hazard pulse
        step(0, 1, 0); step(1, 1, 0); step(0, 1, 0); step(0, 1, 0);
        step(0, 0, 0);

        // long stall drives the stall counter into saturation
        step(1, 0, 0);
        repeat (20) step(0, 1, 0);
        step(0, 0, 0);

        // back-to-back branches stay in FLUSH
        step(0, 0, 1); step(0, 0, 1); step(0, 1, 0); step(0, 1, 0);
        step(0, 0, 0);

        repeat (80) step($urandom_range(0, 19) == 0,
                         $urandom_range(0, 2) != 0,
                         $urandom_range(0, 5) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of stall/flush performance counters.
REQ-002 SHALL have parameter STALL_TIMEOUT, default 3, max consecutive stall cycles before timeout flag.
REQ-003 SHALL have port clk input 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset input 1: synchronous, active-high reset.
REQ-005 SHALL have port DHS input 1: data hazard stall request from DOF-stage hazard detector.
REQ-006 SHALL have port BR_TAKEN input 1: branch/jump resolved taken in EX stage.
REQ-007 SHALL have port PC_HOLD output 1: PC register keeps its value at next edge.
REQ-008 SHALL have port IF_DOF_HOLD output 1: IF/DOF pipeline register keeps its value at next edge.
REQ-009 SHALL have port IF_DOF_FLUSH output 1: IF/DOF register loads NOP at next edge.
REQ-010 SHALL have port DOF_EX_BUBBLE output 1: DOF/EX register loads NOP (RW=0, MW=0, no branch) at next edge.
REQ-011 SHALL have port STALL_TIMEOUT_ERR output 1: sticky flag, DHS held longer than STALL_TIMEOUT cycles.
REQ-012 SHALL have port STALL_CNT output CNT_WIDTH: total stall cycles (only with HSC_PERF_CNT_EN).
REQ-013 SHALL have port FLUSH_CNT output CNT_WIDTH: total flush events (only with HSC_PERF_CNT_EN).

Function
REQ-014 SHALL implement FSM with states RUN, STALL, FLUSH; encoding in shared package.
REQ-015 SHALL drive PC_HOLD, IF_DOF_HOLD, DOF_EX_BUBBLE, IF_DOF_FLUSH combinationally from state and current inputs (zero-cycle latency) so the action applies at the same edge.
REQ-016 RUN, DHS=1, BR_TAKEN=0: assert PC_HOLD, IF_DOF_HOLD, DOF_EX_BUBBLE; next state STALL.
REQ-017 STALL, DHS=1, BR_TAKEN=0: same outputs as REQ-016; stay STALL; increment run-length counter.
REQ-018 STALL or RUN, DHS=0, BR_TAKEN=0: all control outputs 0; next state RUN; run-length counter cleared.
REQ-019 BR_TAKEN=1 in any state: assert IF_DOF_FLUSH and DOF_EX_BUBBLE, deassert both holds; BR_TAKEN has priority over DHS; next state FLUSH.
REQ-020 FLUSH: ignore DHS (DOF holds a NOP); all outputs 0 unless BR_TAKEN=1 (then REQ-019 again, stay FLUSH); else next state RUN.
REQ-021 Run-length counter SHALL saturate at STALL_TIMEOUT; on a cycle in STALL with counter already STALL_TIMEOUT and DHS=1, set STALL_TIMEOUT_ERR.
REQ-022 STALL_TIMEOUT_ERR SHALL remain set until reset; it SHALL NOT alter stalling behaviour.
REQ-023 PC_HOLD and IF_DOF_FLUSH SHALL never be asserted in the same cycle.

Reset
REQ-024 reset=1 at edge: state RUN, run-length 0, STALL_TIMEOUT_ERR 0, STALL_CNT 0, FLUSH_CNT 0.
REQ-025 While reset=1, all combinational control outputs SHALL be 0 regardless of DHS/BR_TAKEN.
REQ-026 Reset mid-STALL or mid-FLUSH SHALL abandon it; first post-reset cycle evaluates as RUN.

Configuration
REQ-027 Macro HSC_PERF_CNT_EN defined: STALL_CNT increments each cycle DOF_EX_BUBBLE=1 due to DHS, FLUSH_CNT each cycle BR_TAKEN=1; both saturate at all-ones.
REQ-028 Macro undefined: counter registers absent; STALL_CNT and FLUSH_CNT tied to 0; ports retained.

Structure
REQ-029 Shared package SHALL hold FSM state encoding (2-bit, RUN=0, STALL=1, FLUSH=2) and default CNT_WIDTH/STALL_TIMEOUT constants.
REQ-030 Saturating counter SHALL be sub-module sat_counter (params WIDTH; inputs clk, reset, inc; output count), instanced twice under HSC_PERF_CNT_EN.

Verification
REQ-031 reset 2 cycles, DHS=0, BR_TAKEN=0 for 5 cycles -> all outputs 0, counters 0.
REQ-032 DHS=1 for 2 cycles then 0 -> PC_HOLD/IF_DOF_HOLD/DOF_EX_BUBBLE high exactly 2 cycles, STALL_CNT=2, ERR=0.
REQ-033 DHS=1 and BR_TAKEN=1 same cycle -> IF_DOF_FLUSH=1, DOF_EX_BUBBLE=1, PC_HOLD=0; next cycle DHS=1 ignored, outputs 0; FLUSH_CNT=1.
REQ-034 DHS=1 for 5 cycles, STALL_TIMEOUT=3 -> ERR sets on cycle 5, stays set after DHS=0, clears only on reset.
REQ-035 Reset asserted during cycle 2 of a 4-cycle DHS pulse -> outputs 0 during reset, state RUN, counters 0; post-reset DHS=1 restarts stall.
REQ-036 Force STALL_CNT near all-ones (CNT_WIDTH=4, 20 stall cycles) -> saturates at 15; without HSC_PERF_CNT_EN reads 0.
